// File: rtl/seq_alu.sv
// Multi-cycle execute unit: single-cycle RV32I ALU ops plus iterative RV32M multiply/divide behind valid/ready.
// Define SEQ_ALU_DIV_EN to build the restoring divider; without it div ops complete at once flagged illegal.
module seq_alu #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            m_op,
   input  logic [3:0]      control,
   input  logic [XLEN-1:0] left_op,
   input  logic [XLEN-1:0] right_op,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero_flag,
   output logic            illegal
);

   localparam int CNT_W = $clog2(XLEN) + 1;
   localparam int SH_W  = $clog2(XLEN);

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;

   localparam logic [2:0] F3_MUL    = 3'd0;
   localparam logic [2:0] F3_MULH   = 3'd1;
   localparam logic [2:0] F3_MULHSU = 3'd2;
   localparam logic [2:0] F3_MULHU  = 3'd3;
   localparam logic [2:0] F3_DIV    = 3'd4;
   localparam logic [2:0] F3_DIVU   = 3'd5;
   localparam logic [2:0] F3_REM    = 3'd6;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state, state_n;
   logic [CNT_W-1:0]  cnt;
   logic [2:0]        op_q;
   logic              neg_q;
   logic [XLEN-1:0]   hi, lo, mcand;
   logic [XLEN-1:0]   hi_n, lo_n;
   logic              accept;
   logic              load_res;
   logic [XLEN-1:0]   alu_res;
   logic [XLEN-1:0]   fin_res;
   logic              fin_ill;
   logic [SH_W-1:0]   shamt;
   logic [2:0]        f3;
   logic              sgn_a, sgn_b, a_neg, b_neg;
   logic [XLEN-1:0]   a_mag, b_mag;
   logic [XLEN:0]     mul_sum;
   logic [XLEN-1:0]   mul_hi_n, mul_lo_n;
   logic [2*XLEN-1:0] prod, prod_fix;

`ifdef SEQ_ALU_DIV_EN
   logic              neg_r;
   logic              div0_q;
   logic [XLEN-1:0]   a_save;
   logic [XLEN:0]     div_shift;
   logic [XLEN+1:0]   div_diff;
   logic              div_ge;
   logic [XLEN-1:0]   div_hi_n, div_lo_n;
   logic [XLEN-1:0]   quo_fix, rem_fix;
`endif

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign accept    = in_valid & in_ready & ~flush;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: begin
            if (accept) begin
               if (!m_op) begin
                  state_n = DONE;
               end else begin
`ifdef SEQ_ALU_DIV_EN
                  state_n = BUSY;
`else
                  state_n = control[2] ? DONE : BUSY;
`endif
               end
            end
         end
         BUSY:    if (cnt == CNT_W'(XLEN - 1)) state_n = DONE;
         DONE:    if (out_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
      if (flush) state_n = IDLE;
   end

   assign shamt = right_op[SH_W-1:0];

   always_comb begin
      alu_res = '0;
      unique case (control)
         ALU_ADD:  alu_res = left_op + right_op;
         ALU_SUB:  alu_res = left_op - right_op;
         ALU_SLL:  alu_res = left_op << shamt;
         ALU_SLT:  alu_res = XLEN'($signed(left_op) < $signed(right_op));
         ALU_SLTU: alu_res = XLEN'(left_op < right_op);
         ALU_XOR:  alu_res = left_op ^ right_op;
         ALU_SRL:  alu_res = left_op >> shamt;
         ALU_SRA:  alu_res = $signed(left_op) >>> shamt;
         ALU_OR:   alu_res = left_op | right_op;
         ALU_AND:  alu_res = left_op & right_op;
         default:  alu_res = '0;
      endcase
   end

   // Iterations run on magnitudes; the sign is reapplied when the result is captured.
   assign f3    = control[2:0];
   assign sgn_a = (f3 == F3_MULH) | (f3 == F3_MULHSU) | (f3 == F3_DIV) | (f3 == F3_REM);
   assign sgn_b = (f3 == F3_MULH) | (f3 == F3_DIV) | (f3 == F3_REM);
   assign a_neg = sgn_a & left_op[XLEN-1];
   assign b_neg = sgn_b & right_op[XLEN-1];
   assign a_mag = a_neg ? -left_op : left_op;
   assign b_mag = b_neg ? -right_op : right_op;

   assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : {(XLEN+1){1'b0}});
   assign mul_hi_n = mul_sum[XLEN:1];
   assign mul_lo_n = {mul_sum[0], lo[XLEN-1:1]};
   assign prod     = {mul_hi_n, mul_lo_n};
   assign prod_fix = neg_q ? -prod : prod;

`ifdef SEQ_ALU_DIV_EN
   assign div_shift = {hi, lo[XLEN-1]};
   assign div_diff  = {1'b0, div_shift} - {2'b00, mcand};
   assign div_ge    = ~div_diff[XLEN+1];
   assign div_hi_n  = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
   assign div_lo_n  = {lo[XLEN-2:0], div_ge};
   // Divide by zero bypasses the sign fix-up; signed overflow falls out of the magnitude path.
   assign quo_fix   = div0_q ? {XLEN{1'b1}} : (neg_q ? -div_lo_n : div_lo_n);
   assign rem_fix   = div0_q ? a_save : (neg_r ? -div_hi_n : div_hi_n);
`endif

   always_comb begin
      hi_n = mul_hi_n;
      lo_n = mul_lo_n;
`ifdef SEQ_ALU_DIV_EN
      if (op_q[2]) begin
         hi_n = div_hi_n;
         lo_n = div_lo_n;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt   <= '0;
         op_q  <= '0;
         neg_q <= 1'b0;
         hi    <= '0;
         lo    <= '0;
         mcand <= '0;
`ifdef SEQ_ALU_DIV_EN
         neg_r  <= 1'b0;
         div0_q <= 1'b0;
         a_save <= '0;
`endif
      end else if (accept && m_op) begin
         cnt   <= '0;
         op_q  <= f3;
         neg_q <= a_neg ^ b_neg;
         hi    <= '0;
         lo    <= a_mag;
         mcand <= b_mag;
`ifdef SEQ_ALU_DIV_EN
         neg_r  <= a_neg;
         div0_q <= (right_op == '0);
         a_save <= left_op;
`endif
      end else if (state == BUSY) begin
         cnt <= cnt + CNT_W'(1);
         hi  <= hi_n;
         lo  <= lo_n;
      end
   end

   always_comb begin
      fin_res = '0;
      fin_ill = 1'b0;
      if (state == IDLE) begin
         if (!m_op) fin_res = alu_res;
`ifndef SEQ_ALU_DIV_EN
         else       fin_ill = 1'b1;
`endif
      end else begin
         unique case (op_q)
            F3_MUL:                       fin_res = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fin_res = prod_fix[2*XLEN-1:XLEN];
`ifdef SEQ_ALU_DIV_EN
            F3_DIV, F3_DIVU:              fin_res = quo_fix;
            default:                      fin_res = rem_fix;
`else
            default:                      fin_res = '0;
`endif
         endcase
      end
   end

   // Outputs are captured only on entry to DONE so they hold steady under backpressure.
   assign load_res = (state != DONE) && (state_n == DONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         result    <= '0;
         zero_flag <= 1'b0;
         illegal   <= 1'b0;
      end else if (load_res) begin
         result    <= fin_res;
         zero_flag <= (fin_res == '0);
         illegal   <= fin_ill;
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: vector table for ALU/MUL/DIV results and latency, plus handshake corner sequences.
module tb_seq_alu;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic        m_op;
   logic [3:0]  control;
   logic [31:0] left_op;
   logic [31:0] right_op;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero_flag;
   logic        illegal;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        m;
      logic [3:0]  ctl;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        ill;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   seq_alu dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .m_op(m_op), .control(control), .left_op(left_op), .right_op(right_op),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero_flag(zero_flag), .illegal(illegal)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   task automatic add_vec(input logic m, input logic [3:0] ctl, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] res, input logic ill, input int lat);
      vec_t v;
      v.m = m; v.ctl = ctl; v.a = a; v.b = b; v.res = res; v.ill = ill; v.lat = lat;
      vecs.push_back(v);
   endtask

   task automatic add_div(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res);
`ifdef SEQ_ALU_DIV_EN
      add_vec(1'b1, ctl, a, b, res, 1'b0, 33);
`else
      add_vec(1'b1, ctl, a, b, 32'h0, 1'b1, 1);
`endif
   endtask

   task automatic start_op(input logic m, input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
      m_op = m; control = ctl; left_op = a; right_op = b; in_valid = 1'b1;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int lat;
      check($sformatf("v%0d_in_ready_pre", idx), {31'b0, in_ready}, 32'd1);
      start_op(v.m, v.ctl, v.a, v.b);
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 100) begin
         tick();
         lat++;
      end
      check($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.lat));
      check($sformatf("v%0d_result", idx), result, v.res);
      check($sformatf("v%0d_zero", idx), {31'b0, zero_flag}, {31'b0, v.res == 32'h0});
      check($sformatf("v%0d_illegal", idx), {31'b0, illegal}, {31'b0, v.ill});
      tick();
      check($sformatf("v%0d_idle_after", idx), {30'b0, out_valid, in_ready}, 32'b01);
   endtask

   initial begin
      int saw_valid;

      // ALU codes: ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9; M funct3 0..7
      add_vec(0, 4'd0,  32'd7,        32'd5,        32'd12,       0, 1);
      add_vec(0, 4'd1,  32'd5,        32'd7,        32'hFFFFFFFE, 0, 1);
      add_vec(0, 4'd1,  32'd9,        32'd9,        32'h0,        0, 1);
      add_vec(0, 4'd2,  32'd1,        32'h3F,       32'h80000000, 0, 1);
      add_vec(0, 4'd3,  32'hFFFFFFFF, 32'd1,        32'd1,        0, 1);
      add_vec(0, 4'd4,  32'hFFFFFFFF, 32'd1,        32'd0,        0, 1);
      add_vec(0, 4'd5,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 0, 1);
      add_vec(0, 4'd6,  32'h80000000, 32'd4,        32'h08000000, 0, 1);
      add_vec(0, 4'd7,  32'h80000000, 32'd4,        32'hF8000000, 0, 1);
      add_vec(0, 4'd8,  32'hF0,       32'h0F,       32'hFF,       0, 1);
      add_vec(0, 4'd9,  32'hF0,       32'h3C,       32'h30,       0, 1);
      add_vec(0, 4'd15, 32'd123,      32'd456,      32'h0,        0, 1);
      add_vec(1, 4'd0,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        0, 33);
      add_vec(1, 4'd3,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 33);
      add_vec(1, 4'd1,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        0, 33);
      add_vec(1, 4'd2,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 33);
      add_vec(1, 4'd1,  32'h80000000, 32'h80000000, 32'h40000000, 0, 33);
      add_vec(1, 4'd0,  32'd12345,    32'hFFFFFFFD, 32'hFFFF6F55, 0, 33);
      add_vec(1, 4'd1,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 0, 33);
      add_div(4'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
      add_div(4'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0);
      add_div(4'd5, 32'd10,       32'd0,        32'hFFFFFFFF);
      add_div(4'd7, 32'd10,       32'd0,        32'd10);
      add_div(4'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD);
      add_div(4'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF);
      add_div(4'd5, 32'd100,      32'd7,        32'd14);
      add_div(4'd7, 32'd100,      32'd7,        32'd2);
      add_div(4'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD);
      add_div(4'd6, 32'd7,        32'hFFFFFFFE, 32'd1);

      reset = 1'b1; in_valid = 1'b0; m_op = 1'b0; control = 4'd0;
      left_op = '0; right_op = '0; flush = 1'b0; out_ready = 1'b1;
      tick(); tick();
      reset = 1'b0;
      check("reset_outputs", {out_valid, zero_flag, illegal, in_ready}, 4'b0001);
      check("reset_result", result, 32'h0);

      foreach (vecs[i]) run_vec(vecs[i], i);

      // Back-to-back: one op every two cycles with in_valid held high.
      start_op(0, 4'd0, 32'd1, 32'd2);
      tick();
      check("b2b_first", {out_valid, in_ready}, 2'b10);
      check("b2b_first_res", result, 32'd3);
      start_op(0, 4'd0, 32'd5, 32'd5);
      tick();
      check("b2b_gap", {out_valid, in_ready}, 2'b01);
      tick();
      in_valid = 1'b0;
      check("b2b_second", {out_valid, in_ready}, 2'b10);
      check("b2b_second_res", result, 32'd10);
      tick();

      // Backpressure: result held and new inputs ignored while out_ready is low.
      out_ready = 1'b0;
      start_op(0, 4'd0, 32'd3, 32'd4);
      tick();
      start_op(0, 4'd1, 32'd100, 32'd1);
      for (int k = 0; k < 10; k++) begin
         check($sformatf("bp_hold%0d", k), {out_valid, in_ready, zero_flag, illegal}, 4'b1000);
         check($sformatf("bp_res%0d", k), result, 32'd7);
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      check("bp_release", {out_valid, in_ready}, 2'b01);
      check("bp_release_res", result, 32'd7);

      // Flush in IDLE wins over a simultaneous request.
      start_op(0, 4'd0, 32'd8, 32'd8);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      check("flush_idle_noaccept", {out_valid, in_ready}, 2'b01);
      tick();
      check("flush_idle_still", {out_valid, in_ready}, 2'b01);

      // Flush five cycles into a MUL with in_valid held, then next op goes through.
      start_op(1, 4'd0, 32'd6, 32'd7);
      tick();
      start_op(0, 4'd0, 32'd20, 32'd22);
      saw_valid = 0;
      for (int k = 0; k < 4; k++) begin
         if (out_valid || in_ready) saw_valid = 1;
         tick();
      end
      check("flush_busy_pre", 32'(saw_valid), 32'd0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_busy_after", {out_valid, in_ready}, 2'b01);
      tick();
      in_valid = 1'b0;
      check("flush_next_valid", {out_valid, in_ready}, 2'b10);
      check("flush_next_res", result, 32'd42);
      tick();

      // Reset in the middle of a long op clears every output.
      start_op(1, 4'd2, 32'd5, 32'd3);
      tick();
      in_valid = 1'b0;
      while (!out_valid && checks < 100000) tick();
      tick();
`ifdef SEQ_ALU_DIV_EN
      start_op(1, 4'd5, 32'd100, 32'd7);
`else
      start_op(1, 4'd0, 32'd100, 32'd7);
`endif
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midreset_flags", {out_valid, zero_flag, illegal, in_ready}, 4'b0001);
      check("midreset_result", result, 32'h0);
      for (int k = 0; k < 40; k++) begin
         if (out_valid) saw_valid = 1;
         tick();
      end
      check("midreset_no_valid", 32'(saw_valid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
